uart_tx_ext: RTL and testbench

//  Parametrised UART transmitter with integrated TX FIFO, the next generation of the 8-bit TX.

---
 rtl/uart_pkg.sv | 63 ++++++
 rtl/uart_tx_ext_fifo.sv | 78 +++++++
 rtl/uart_tx_ext.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_uart_tx_ext.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the UART transmitter slice.
//   Contents:
//     tx_state_t     transmitter FSM states
//     parity_mode_t  decoded parity selection
//     stop_mode_t    decoded stop-bit length selection
//     MIN_DATA_BITS  smallest data length a frame may carry
//     MIN_BAUD       smallest legal clocks-per-bit value
//     decode_parity / decode_stop / clamp_baud helper functions
package uart_pkg;

  localparam int MIN_DATA_BITS = 5;
  localparam int MIN_BAUD      = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK,
    ST_BREAK_MARK
  } tx_state_t;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_mode_t;

  typedef enum logic [1:0] {
    STOP_ONE      = 2'd0,
    STOP_ONE_HALF = 2'd1,
    STOP_TWO      = 2'd2
  } stop_mode_t;

  // Register encodings 5..7 are reserved and behave as "no parity".
  function automatic parity_mode_t decode_parity(input logic [2:0] mode);
    case (mode)
      3'd1:    return PAR_EVEN;
      3'd2:    return PAR_ODD;
      3'd3:    return PAR_MARK;
      3'd4:    return PAR_SPACE;
      default: return PAR_NONE;
    endcase
  endfunction

  // Encodings 2 and 3 both select two stop bits.
  function automatic stop_mode_t decode_stop(input logic [1:0] mode);
    case (mode)
      2'd0:    return STOP_ONE;
      2'd1:    return STOP_ONE_HALF;
      default: return STOP_TWO;
    endcase
  endfunction

  function automatic logic [23:0] clamp_baud(input logic [23:0] baud);
    return (baud < 24'(MIN_BAUD)) ? 24'(MIN_BAUD) : baud;
  endfunction

endpackage

// File: rtl/uart_tx_ext_fifo.sv
// fifo_stack
//   Synchronous first-in first-out buffer used as the UART TX holding queue.
//   Ports:
//     clk, reset   clock and asynchronous active-high reset
//     clear        synchronous flush; occupancy is 0 on the next cycle
//     push         write data_in (ignored while full or while clearing)
//     pop          drop the head word (ignored while empty)
//     data_in      word to write
//     data_out     current head word (valid while !empty)
//     size         occupancy, 0..2**ADDR_WIDTH
//     empty, full  occupancy flags
module fifo_stack #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   size,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   size_q, size_d;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (size_q == '0);
  assign full     = (size_q == (ADDR_WIDTH + 1)'(DEPTH));
  assign size     = size_q;
  assign data_out = mem_q[rd_ptr_q];

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // A simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    size_d   = size_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      size_d   = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      size_d = size_q + (ADDR_WIDTH + 1)'(do_push) - (ADDR_WIDTH + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      size_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      size_q   <= size_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/uart_tx_ext.sv
// uart_tx_ext
//   UART transmitter with an integrated TX FIFO, configurable frame format,
//   hardware flow control and break generation.
//   Ports:
//     clk, reset    clock and asynchronous active-high reset
//     clear         synchronous FIFO flush (frame in flight still completes)
//     tx            serial output, idle high
//     cts           clear-to-send, active low, asynchronous
//     flow_ctrl     1: a frame may only start while synchronised cts is low
//     parity_mode   0 none, 1 even, 2 odd, 3 mark, 4 space, 5..7 none
//     stop_mode     0 one, 1 one-and-a-half, 2/3 two stop bits
//     data_len      data bits per frame, clamped to 5..DATA_WIDTH
//     baud_reg      clocks per bit, values below 2 act as 2
//     break_req     level request to hold the line low
//     push, data_in FIFO write port (data sent LSB first)
//     size, empty, full  FIFO status
//     busy          high whenever the FSM is not idle
//     tx_done       one-cycle pulse during the last stop-bit clock of a frame
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  tx,
  input  logic                  cts,
  input  logic                  flow_ctrl,
  input  logic [2:0]            parity_mode,
  input  logic [1:0]            stop_mode,
  input  logic [3:0]            data_len,
  input  logic [23:0]           baud_reg,
  input  logic                  break_req,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH:0]   size,
  output logic                  empty,
  output logic                  full,
  output logic                  busy,
  output logic                  tx_done
);

  // FIFO interface
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_empty;
  logic                  fifo_pop;

  // Launch-time decode of the live configuration inputs
  logic [3:0]   len_clamped;
  logic         head_xor;
  logic         head_par_bit;
  parity_mode_t launch_par;

  // FSM, timing and latched frame state
  tx_state_t             state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  tx_done_q, tx_done_d;
  logic [24:0]           cnt_q, cnt_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [3:0]            len_q, len_d;
  parity_mode_t          par_q, par_d;
  logic                  par_bit_q, par_bit_d;
  stop_mode_t            stop_q, stop_d;
  logic [23:0]           baud_q, baud_d;
  logic                  cts_meta_q, cts_sync_q;

  logic [24:0] stop_len;
  logic        bit_end;
  logic        stop_end;
  logic        stop_pre_end;
  logic        launch_ok;

  fifo_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .push     (push),
    .pop      (fifo_pop),
    .data_in  (data_in),
    .data_out (fifo_head),
    .size     (size),
    .empty    (fifo_empty),
    .full     (full)
  );

  assign empty   = fifo_empty;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

  // cts is asynchronous; synchroniser resets to "not clear to send".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts;
      cts_sync_q <= cts_meta_q;
    end
  end

  always_comb begin
    if (data_len < 4'(MIN_DATA_BITS))    len_clamped = 4'(MIN_DATA_BITS);
    else if (data_len > 4'(DATA_WIDTH))  len_clamped = 4'(DATA_WIDTH);
    else                                 len_clamped = data_len;
  end

  // Parity is resolved at launch so bits above the frame length never leak in.
  always_comb begin
    head_xor = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (4'(i) < len_clamped) head_xor = head_xor ^ fifo_head[i];
    end
    launch_par = decode_parity(parity_mode);
    case (launch_par)
      PAR_EVEN: head_par_bit = head_xor;
      PAR_ODD:  head_par_bit = ~head_xor;
      PAR_MARK: head_par_bit = 1'b1;
      default:  head_par_bit = 1'b0;
    endcase
  end

  always_comb begin
    case (stop_q)
      STOP_ONE:      stop_len = {1'b0, baud_q};
      STOP_ONE_HALF: stop_len = {1'b0, baud_q} + {2'b0, baud_q[23:1]};
      default:       stop_len = {baud_q, 1'b0};
    endcase
  end

  assign bit_end      = (cnt_q == ({1'b0, baud_q} - 25'd1));
  assign stop_end     = (cnt_q == (stop_len - 25'd1));
  // stop_len is at least 2, so the pre-end compare never underflows.
  assign stop_pre_end = (cnt_q == (stop_len - 25'd2));
  assign launch_ok    = !fifo_empty && (!flow_ctrl || !cts_sync_q);

  // Next-state logic. tx and tx_done are computed one cycle ahead so the
  // registered copies line up exactly with the state they belong to.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    len_d     = len_q;
    par_d     = par_q;
    par_bit_d = par_bit_q;
    stop_d    = stop_q;
    baud_d    = baud_q;
    tx_done_d = 1'b0;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (break_req) begin
          state_d = ST_BREAK;
          tx_d    = 1'b0;
          baud_d  = clamp_baud(baud_reg);
        end else if (launch_ok) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_head;
          len_d     = len_clamped;
          par_d     = launch_par;
          par_bit_d = head_par_bit;
          stop_d    = decode_stop(stop_mode);
          baud_d    = clamp_baud(baud_reg);
          tx_d      = 1'b0;
          state_d   = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == (len_q - 4'd1)) begin
            if (par_q != PAR_NONE) begin
              tx_d    = par_bit_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = shift_q[1];
            shift_d   = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end

      ST_STOP: begin
        tx_done_d = stop_pre_end;
        if (stop_end) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end

      ST_BREAK: begin
        cnt_d = '0;
        if (!break_req) begin
          tx_d    = 1'b1;
          state_d = ST_BREAK_MARK;
        end
      end

      ST_BREAK_MARK: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      len_q     <= 4'(MIN_DATA_BITS);
      par_q     <= PAR_NONE;
      par_bit_q <= 1'b0;
      stop_q    <= STOP_ONE;
      baud_q    <= 24'(MIN_BAUD);
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      len_q     <= len_d;
      par_q     <= par_d;
      par_bit_q <= par_bit_d;
      stop_q    <= stop_d;
      baud_q    <= baud_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ext.sv
// tb_uart_tx_ext
//   Scoreboard bench for uart_tx_ext: stimulus queues hand-computed frame
//   descriptions, a monitor decodes the tx line cycle by cycle against them.
module tb_uart_tx_ext;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        tx;
  logic        cts;
  logic        flow_ctrl;
  logic [2:0]  parity_mode;
  logic [1:0]  stop_mode;
  logic [3:0]  data_len;
  logic [23:0] baud_reg;
  logic        break_req;
  logic        push;
  logic [8:0]  data_in;
  logic [5:0]  size;
  logic        empty;
  logic        full;
  logic        busy;
  logic        tx_done;

  typedef struct {
    logic [8:0] bits;
    int         len;
    bit         has_par;
    logic       par;
    int         baud;
    int         stop;
    bit         b2b;
  } exp_frame_t;

  exp_frame_t exp_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;
  int frames_seen  = 0;
  bit mon_active   = 0;

  uart_tx_ext #(.ADDR_WIDTH(5), .DATA_WIDTH(9)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .tx          (tx),
    .cts         (cts),
    .flow_ctrl   (flow_ctrl),
    .parity_mode (parity_mode),
    .stop_mode   (stop_mode),
    .data_len    (data_len),
    .baud_reg    (baud_reg),
    .break_req   (break_req),
    .push        (push),
    .data_in     (data_in),
    .size        (size),
    .empty       (empty),
    .full        (full),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Observe one bit period; 'here' means the first cycle is the current sample.
  task automatic samplePeriod(input string name, input logic exp_tx, input int ncyc,
                              input bit done_last, input bit here);
    logic tx_obs;
    int   done_cnt;
    bit   done_bad;
    tx_obs   = exp_tx;
    done_cnt = 0;
    done_bad = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (!(here && c == 0)) @(negedge clk);
      if (tx !== exp_tx) tx_obs = tx;
      if (tx_done !== 1'b0) begin
        done_cnt++;
        if (!(done_last && c == ncyc - 1)) done_bad = 1;
      end
    end
    checkOutput({name, " tx"}, 32'(tx_obs), 32'(exp_tx));
    checkOutput({name, " tx_done"}, done_bad ? 32'hBAD : 32'(done_cnt), done_last ? 32'd1 : 32'd0);
  endtask

  task automatic applyStimulus(input logic [8:0] word, input logic [3:0] len_cfg,
                               input logic [2:0] par_cfg, input logic [1:0] stop_cfg,
                               input logic [23:0] baud_cfg, input logic [8:0] exp_bits,
                               input int exp_len, input bit exp_has_par, input logic exp_par,
                               input int exp_baud, input int exp_stop);
    exp_frame_t e;
    @(negedge clk);
    data_len    = len_cfg;
    parity_mode = par_cfg;
    stop_mode   = stop_cfg;
    baud_reg    = baud_cfg;
    e.bits = exp_bits; e.len = exp_len; e.has_par = exp_has_par; e.par = exp_par;
    e.baud = exp_baud; e.stop = exp_stop; e.b2b = 0;
    exp_q.push_back(e);
    push    = 1'b1;
    data_in = word;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic waitFrameDone(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) checkOutput({name, " frame timeout"}, 32'd0, 32'd1);
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !mon_active && busy === 1'b0 && empty === 1'b1) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) checkOutput({name, " idle timeout"}, 32'd0, 32'd1);
  endtask

  // Monitor: takes the next expected frame and checks the line against it.
  initial begin : monitor
    exp_frame_t e;
    int idle_cnt;
    bit got;
    int fidx;
    fidx = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        mon_active = 1;
        got = 0;
        idle_cnt = 0;
        for (int w = 0; w < 5000; w++) begin
          if (w != 0) @(negedge clk);
          if (tx === 1'b0) begin
            got = 1;
            break;
          end
          idle_cnt++;
        end
        if (!got) begin
          checkOutput($sformatf("f%0d start timeout", fidx), 32'd0, 32'd1);
        end else begin
          if (e.b2b)
            checkOutput($sformatf("f%0d idle gap", fidx),
                        (idle_cnt <= 1) ? 32'd1 : 32'(idle_cnt), 32'd1);
          samplePeriod($sformatf("f%0d start", fidx), 1'b0, e.baud, 0, 1);
          for (int i = 0; i < e.len; i++)
            samplePeriod($sformatf("f%0d d%0d", fidx, i), e.bits[i], e.baud, 0, 0);
          if (e.has_par)
            samplePeriod($sformatf("f%0d parity", fidx), e.par, e.baud, 0, 0);
          samplePeriod($sformatf("f%0d stop", fidx), 1'b1, e.stop, 1, 0);
          frames_seen++;
        end
        fidx++;
        mon_active = 0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic obs;
    logic obs2;
    int   lat;
    int   f0;
    exp_frame_t e;

    reset = 1'b1; clear = 1'b0; cts = 1'b0; flow_ctrl = 1'b0;
    parity_mode = 3'd0; stop_mode = 2'd0; data_len = 4'd8; baud_reg = 24'd4;
    break_req = 1'b0; push = 1'b0; data_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset tx", 32'(tx), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset tx_done", 32'(tx_done), 32'd0);
    checkOutput("reset empty", 32'(empty), 32'd1);
    checkOutput("reset full", 32'(full), 32'd0);
    checkOutput("reset size", 32'(size), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5, 8N1 at 4 clocks per bit
    applyStimulus(9'h0A5, 4'd8, 3'd0, 2'd0, 24'd4, 9'h0A5, 8, 0, 1'b0, 4, 4);
    checkOutput("t1 size after push", 32'(size), 32'd1);
    checkOutput("t1 empty after push", 32'(empty), 32'd0);
    waitIdle("t1");

    // 7 data bits even parity, two stop bits; config changed mid-frame
    applyStimulus(9'h17F, 4'd7, 3'd1, 2'd2, 24'd4, 9'h07F, 7, 1, 1'b1, 4, 8);
    repeat (5) @(negedge clk);
    data_len = 4'd8; parity_mode = 3'd0; stop_mode = 2'd0; baud_reg = 24'd3;
    waitIdle("t2a");
    // Same word, odd parity
    applyStimulus(9'h17F, 4'd7, 3'd2, 2'd2, 24'd4, 9'h07F, 7, 1, 1'b0, 4, 8);
    waitIdle("t2b");
    // data_len 3 clamps to 5; mark parity
    applyStimulus(9'h1E0, 4'd3, 3'd3, 2'd0, 24'd3, 9'h000, 5, 1, 1'b1, 3, 3);
    waitIdle("t2c");
    // Space parity
    applyStimulus(9'h01F, 4'd5, 3'd4, 2'd0, 24'd3, 9'h01F, 5, 1, 1'b0, 3, 3);
    waitIdle("t2d");
    // data_len 15 clamps to 9; parity encoding 7 means none; stop_mode 3 is two
    applyStimulus(9'h155, 4'd15, 3'd7, 2'd3, 24'd3, 9'h155, 9, 0, 1'b0, 3, 6);
    waitIdle("t2e");

    // One-and-a-half stop bits at 5 clocks per bit: 7 clocks
    applyStimulus(9'h055, 4'd8, 3'd0, 2'd1, 24'd5, 9'h055, 8, 0, 1'b0, 5, 7);
    waitIdle("t3a");
    // baud 1 and 0 both act as 2
    applyStimulus(9'h0C3, 4'd8, 3'd0, 2'd0, 24'd1, 9'h0C3, 8, 0, 1'b0, 2, 2);
    waitIdle("t3b");
    applyStimulus(9'h03C, 4'd8, 3'd0, 2'd1, 24'd0, 9'h03C, 8, 0, 1'b0, 2, 3);
    waitIdle("t3c");

    // Flow control: held off while cts high, launches 3 clocks after cts low
    @(negedge clk);
    flow_ctrl = 1'b1; cts = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(9'h03C, 4'd8, 3'd0, 2'd0, 24'd4, 9'h03C, 8, 0, 1'b0, 4, 4);
    obs = 1'b1; obs2 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) obs = tx;
      if (busy !== 1'b0) obs2 = busy;
    end
    checkOutput("t5 tx held by cts", 32'(obs), 32'd1);
    checkOutput("t5 busy held by cts", 32'(obs2), 32'd0);
    cts = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        lat = c;
        break;
      end
    end
    checkOutput("t5 cts launch latency", 32'(lat), 32'd3);
    repeat (8) @(negedge clk);
    cts = 1'b1;
    waitIdle("t5");

    // Fill the FIFO with cts blocking, overflow once, then drain back-to-back
    baud_reg = 24'd2; data_len = 4'd8; parity_mode = 3'd0; stop_mode = 2'd0;
    f0 = frames_seen;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (i == 32) begin
        checkOutput("t4 size at 32", 32'(size), 32'd32);
        checkOutput("t4 full at 32", 32'(full), 32'd1);
      end else begin
        e.bits = 9'(i); e.len = 8; e.has_par = 0; e.par = 1'b0;
        e.baud = 2; e.stop = 2; e.b2b = (i != 0);
        exp_q.push_back(e);
      end
      push = 1'b1;
      data_in = (i == 32) ? 9'h1FF : 9'(i);
    end
    @(negedge clk);
    push = 1'b0;
    checkOutput("t4 size after overflow", 32'(size), 32'd32);
    checkOutput("t4 full after overflow", 32'(full), 32'd1);
    cts = 1'b0;
    waitIdle("t4");
    checkOutput("t4 frames sent", 32'(frames_seen - f0), 32'd32);
    flow_ctrl = 1'b0;

    // Clear: push+pop keeps size, flush drops queued words, frame in flight completes
    e.bits = 9'h0E1; e.len = 8; e.has_par = 0; e.par = 1'b0; e.baud = 2; e.stop = 2; e.b2b = 0;
    exp_q.push_back(e);
    @(negedge clk);
    push = 1'b1; data_in = 9'h0E1;
    @(negedge clk);
    data_in = 9'h022;
    @(negedge clk);
    checkOutput("t7 size push+pop", 32'(size), 32'd1);
    data_in = 9'h033;
    @(negedge clk);
    push = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("t7 size after clear", 32'(size), 32'd0);
    checkOutput("t7 empty after clear", 32'(empty), 32'd1);
    waitFrameDone("t7");
    obs = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) obs = tx;
    end
    checkOutput("t7 no flushed frames", 32'(obs), 32'd1);

    // Break requested mid-frame: frame completes, line low, then one bit of mark
    applyStimulus(9'h00F, 4'd8, 3'd0, 2'd0, 24'd4, 9'h00F, 8, 0, 1'b0, 4, 4);
    repeat (6) @(negedge clk);
    break_req = 1'b1;
    waitFrameDone("t6");
    repeat (2) @(negedge clk);
    checkOutput("t6 break tx", 32'(tx), 32'd0);
    checkOutput("t6 break busy", 32'(busy), 32'd1);
    obs = 1'b0; obs2 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (tx !== 1'b0) obs = tx;
      if (tx_done !== 1'b0) obs2 = tx_done;
    end
    checkOutput("t6 break hold tx", 32'(obs), 32'd0);
    checkOutput("t6 break tx_done", 32'(obs2), 32'd0);
    break_req = 1'b0;
    obs = 1'b1; obs2 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) obs = tx;
      if (busy !== 1'b1) obs2 = busy;
    end
    checkOutput("t6 mark tx", 32'(obs), 32'd1);
    checkOutput("t6 mark busy", 32'(obs2), 32'd1);
    @(negedge clk);
    checkOutput("t6 idle after mark", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a frame
    @(negedge clk);
    push = 1'b1; data_in = 9'h000;
    @(negedge clk);
    data_in = 9'h011;
    @(negedge clk);
    push = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("t8 reset tx", 32'(tx), 32'd1);
    checkOutput("t8 reset busy", 32'(busy), 32'd0);
    checkOutput("t8 reset empty", 32'(empty), 32'd1);
    checkOutput("t8 reset size", 32'(size), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    obs = 1'b1; obs2 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) obs = tx;
      if (busy !== 1'b0) obs2 = busy;
    end
    checkOutput("t8 line idle after reset", 32'(obs), 32'd1);
    checkOutput("t8 busy idle after reset", 32'(obs2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
